// File: rtl/snake_pkg.sv
// Shared grid geometry, direction/state encodings and reset body for the snake controller.
package snake_pkg;

  localparam int unsigned GRID_W = 40;
  localparam int unsigned GRID_H = 30;

  localparam logic [5:0] WALL_X_LO = 6'd0;
  localparam logic [5:0] WALL_X_HI = 6'(GRID_W - 1);
  localparam logic [5:0] WALL_Y_LO = 6'd0;
  localparam logic [5:0] WALL_Y_HI = 6'(GRID_H - 1);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [5:0] HEAD_X0 = 6'd10;
  localparam logic [5:0] HEAD_Y0 = 6'd15;
  localparam dir_t       DIR0    = DIR_RIGHT;

  // Reset body is a horizontal line trailing left of the head.
  function automatic logic [5:0] init_seg_x(input int unsigned idx);
    return HEAD_X0 - 6'(idx);
  endfunction

  // Encoding pairs opposites in the LSB.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_move_ctrl_if.sv
// Key/event inputs, head/length/status outputs and the renderer body query of snake_move_ctrl.
interface snake_move_ctrl_if;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       start;
  logic       add_cube;
  logic       hit_stone;
  logic [5:0] q_x;
  logic [5:0] q_y;
  logic [5:0] head_x;
  logic [5:0] head_y;
  logic [5:0] snake_len;
  logic       q_body;
  logic       game_over;
  logic       step;

  modport slave (
    input  key_up, key_down, key_left, key_right, start, add_cube, hit_stone, q_x, q_y,
    output head_x, head_y, snake_len, q_body, game_over, step
  );

  modport master (
    output key_up, key_down, key_left, key_right, start, add_cube, hit_stone, q_x, q_y,
    input  head_x, head_y, snake_len, q_body, game_over, step
  );
endinterface

// File: rtl/snake_step_timer.sv
// Move-interval counter: pulses step on the last cycle of each period, cleared while not running.
module snake_step_timer #(
  parameter int unsigned STEP_CYCLES = 6250000,
  parameter int unsigned PW          = $clog2(STEP_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [PW-1:0] period,
  output logic          step
);

  localparam int unsigned TW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

  logic [TW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (PW'(r_cnt) == (period - PW'(1)));
  assign step = run & w_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run || w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake motion controller: direction latch, body shift store, growth, collisions and game FSM.
// Define SNAKE_SPEEDUP_EN to shorten the step period as the snake grows.
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 6250000,
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned INIT_LEN    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  snake_move_ctrl_if.slave  bus
);

  localparam int unsigned PW         = $clog2(STEP_CYCLES + 1);
  localparam logic [5:0]  MAX_LEN_L  = 6'(MAX_LEN);
  localparam logic [5:0]  INIT_LEN_L = 6'(INIT_LEN);

  state_t     r_state;
  dir_t       r_dir;
  dir_t       r_pend;
  logic [5:0] r_len;
  logic       r_grow;
  logic [5:0] r_seg_x [MAX_LEN];
  logic [5:0] r_seg_y [MAX_LEN];

  logic          w_run;
  logic          w_step;
  logic [PW-1:0] w_period;
  logic          w_key_vld;
  dir_t          w_key_dir;
  logic          w_dir_ok;
  logic [5:0]    w_nx;
  logic [5:0]    w_ny;
  logic          w_grow;
  logic          w_wall;
  logic          w_self;
  logic          w_qhit;

  assign w_run = (r_state == ST_RUN);

  snake_step_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .PW          (PW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (w_run),
    .period (w_period),
    .step   (w_step)
  );

`ifdef SNAKE_SPEEDUP_EN
  logic [PW-1:0] r_period;
  logic [31:0]   w_extra;

  assign w_extra  = (32'(r_len) - INIT_LEN) * (STEP_CYCLES / 64);
  assign w_period = r_period;

  // Period only changes at a wrap so the running count never overshoots it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= PW'(STEP_CYCLES);
    end else if (r_state == ST_OVER && bus.start) begin
      r_period <= PW'(STEP_CYCLES);
    end else if (w_step) begin
      if (w_extra > (STEP_CYCLES - STEP_CYCLES / 4)) begin
        r_period <= PW'(STEP_CYCLES / 4);
      end else begin
        r_period <= PW'(STEP_CYCLES - w_extra);
      end
    end
  end
`else
  assign w_period = PW'(STEP_CYCLES);
`endif

  always_comb begin
    w_key_vld = 1'b1;
    w_key_dir = DIR_UP;
    if (bus.key_up)         w_key_dir = DIR_UP;
    else if (bus.key_down)  w_key_dir = DIR_DOWN;
    else if (bus.key_left)  w_key_dir = DIR_LEFT;
    else if (bus.key_right) w_key_dir = DIR_RIGHT;
    else                    w_key_vld = 1'b0;
  end

  // A reversing key is dropped rather than falling through to a lower-priority key.
  assign w_dir_ok = w_key_vld && (w_key_dir != opposite(r_dir));

  always_comb begin
    w_nx = r_seg_x[0];
    w_ny = r_seg_y[0];
    case (r_pend)
      DIR_UP:    w_ny = r_seg_y[0] - 6'd1;
      DIR_DOWN:  w_ny = r_seg_y[0] + 6'd1;
      DIR_LEFT:  w_nx = r_seg_x[0] - 6'd1;
      default:   w_nx = r_seg_x[0] + 6'd1;
    endcase
  end

  assign w_grow = (r_grow || bus.add_cube) && (r_len < MAX_LEN_L);
  assign w_wall = (w_nx == WALL_X_LO) || (w_nx == WALL_X_HI) ||
                  (w_ny == WALL_Y_LO) || (w_ny == WALL_Y_HI);

  // The tail vacates its cell on a plain move, so it only blocks when growing.
  always_comb begin
    w_self = 1'b0;
    for (int unsigned i = 1; i < MAX_LEN; i++) begin
      if (((i + 1 < 32'(r_len)) || (w_grow && (i + 1 == 32'(r_len)))) &&
          (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny)) begin
        w_self = 1'b1;
      end
    end
  end

  always_comb begin
    w_qhit = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((i < 32'(r_len)) && (r_seg_x[i] == bus.q_x) && (r_seg_y[i] == bus.q_y)) begin
        w_qhit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR0;
      r_pend  <= DIR0;
      r_len   <= INIT_LEN_L;
      r_grow  <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= init_seg_x(i);
        r_seg_y[i] <= HEAD_Y0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_dir_ok) r_pend <= w_key_dir;
          if (bus.hit_stone) begin
            r_state <= ST_OVER;
          end else if (w_step) begin
            r_grow <= 1'b0;
            if (w_wall || w_self) begin
              r_state <= ST_OVER;
            end else begin
              for (int unsigned i = 1; i < MAX_LEN; i++) begin
                r_seg_x[i] <= r_seg_x[i-1];
                r_seg_y[i] <= r_seg_y[i-1];
              end
              r_seg_x[0] <= w_nx;
              r_seg_y[0] <= w_ny;
              r_dir      <= r_pend;
              if (w_grow) r_len <= r_len + 6'd1;
            end
          end else if (bus.add_cube) begin
            r_grow <= 1'b1;
          end
        end
        ST_OVER: begin
          if (bus.start) begin
            r_state <= ST_RUN;
            r_dir   <= DIR0;
            r_pend  <= DIR0;
            r_len   <= INIT_LEN_L;
            r_grow  <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
              r_seg_x[i] <= init_seg_x(i);
              r_seg_y[i] <= HEAD_Y0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.head_x    = r_seg_x[0];
  assign bus.head_y    = r_seg_y[0];
  assign bus.snake_len = r_len;
  assign bus.q_body    = w_qhit;
  assign bus.game_over = (r_state == ST_OVER);
  assign bus.step      = w_step;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl with STEP_CYCLES=4: per-move vector table plus wall/stone/reset sequences.
module tb_snake_move_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snake_move_ctrl_if bus();

  snake_move_ctrl #(
    .STEP_CYCLES (4),
    .MAX_LEN     (32),
    .INIT_LEN    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [6:0] M_NONE  = 7'b0000000;
  localparam logic [6:0] M_START = 7'b1000000;
  localparam logic [6:0] M_ADD   = 7'b0100000;
  localparam logic [6:0] M_STONE = 7'b0010000;
  localparam logic [6:0] M_UP    = 7'b0001000;
  localparam logic [6:0] M_DOWN  = 7'b0000100;
  localparam logic [6:0] M_LEFT  = 7'b0000010;
  localparam logic [6:0] M_RIGHT = 7'b0000001;

  // k: idle cycles after the previous move before m1 is driven (3 = coincides with the step)
  typedef struct {
    bit         restart;
    int         k;
    logic [6:0] m1;
    logic [6:0] m2;
    int         ex;
    int         ey;
    int         elen;
    bit         eover;
    int         qx;
    int         qy;
    bit         eqb;
  } vec_t;

  vec_t vecs [17];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   moved;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] m);
    {bus.start, bus.add_cube, bus.hit_stone, bus.key_up, bus.key_down, bus.key_left, bus.key_right} = m;
  endtask

  task automatic tick();
    if (bus.step === 1'b1) moved = 1'b1;
    @(negedge clk);
  endtask

  task automatic finish_move(input string name);
    int n = 0;
    while (!moved && n < 20) begin
      tick();
      n++;
    end
    check(name, int'(moved), 1);
  endtask

  task automatic restart();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(M_START);
    tick();
    drive(M_NONE);
  endtask

  task automatic count_steps(input int cycles, output int steps);
    steps = 0;
    for (int c = 0; c < cycles; c++) begin
      if (bus.step === 1'b1) steps++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps;
    int hx;

    //            rst k  m1               m2     x   y  len over qx  qy  qb
    vecs[0]  = '{1, 0, M_NONE,          M_NONE, 11, 15, 3, 0,  9, 15, 1};
    vecs[1]  = '{0, 0, M_LEFT,          M_UP,   11, 14, 3, 0,  9, 15, 0};
    vecs[2]  = '{0, 0, M_DOWN,          M_NONE, 11, 13, 3, 0, 11, 15, 1};
    vecs[3]  = '{0, 1, M_RIGHT,         M_NONE, 12, 13, 3, 0, 11, 15, 0};
    vecs[4]  = '{0, 2, M_ADD,           M_NONE, 13, 13, 4, 0, 11, 14, 1};
    vecs[5]  = '{0, 3, M_ADD,           M_NONE, 14, 13, 5, 0, 11, 14, 1};
    vecs[6]  = '{0, 0, M_START,         M_NONE, 15, 13, 5, 0, 11, 14, 0};
    vecs[7]  = '{0, 0, M_UP | M_DOWN,   M_NONE, 15, 12, 5, 0, 12, 13, 1};
    vecs[8]  = '{0, 0, M_LEFT | M_RIGHT, M_NONE, 14, 12, 5, 0, 12, 13, 0};
    vecs[9]  = '{0, 1, M_RIGHT,         M_NONE, 13, 12, 5, 0, 14, 13, 1};
    vecs[10] = '{0, 0, M_DOWN | M_RIGHT, M_NONE, 13, 13, 5, 0, 13, 13, 1};
    // 4-long snake circling a 2x2 square: the head re-enters the tail cell each lap
    vecs[11] = '{1, 0, M_ADD,           M_NONE, 11, 15, 4, 0,  8, 15, 1};
    vecs[12] = '{0, 0, M_UP,            M_NONE, 11, 14, 4, 0,  8, 15, 0};
    vecs[13] = '{0, 0, M_LEFT,          M_NONE, 10, 14, 4, 0, 10, 15, 1};
    vecs[14] = '{0, 0, M_DOWN,          M_NONE, 10, 15, 4, 0, 11, 15, 1};
    vecs[15] = '{0, 0, M_RIGHT,         M_NONE, 11, 15, 4, 0, 11, 14, 1};
    vecs[16] = '{0, 1, M_UP,            M_ADD,  11, 15, 4, 1, 11, 14, 1};

    drive(M_NONE);
    bus.q_x = 6'd9;
    bus.q_y = 6'd15;
    repeat (2) @(negedge clk);

    check("rst head_x", int'(bus.head_x), 10);
    check("rst head_y", int'(bus.head_y), 15);
    check("rst len", int'(bus.snake_len), 3);
    check("rst game_over", int'(bus.game_over), 0);
    check("rst step", int'(bus.step), 0);
    check("rst q_body 9,15", int'(bus.q_body), 1);
    bus.q_x = 6'd7;
    #1;
    check("rst q_body 7,15", int'(bus.q_body), 0);

    rst_n = 1'b1;
    drive(M_UP | M_LEFT);
    count_steps(10, steps);
    drive(M_NONE);
    check("idle steps", steps, 0);
    check("idle head_x", int'(bus.head_x), 10);
    check("idle head_y", int'(bus.head_y), 15);

    for (int r = 0; r < 17; r++) begin
      if (vecs[r].restart) restart();
      moved = 1'b0;
      repeat (vecs[r].k) tick();
      drive(vecs[r].m1);
      tick();
      drive(M_NONE);
      if (vecs[r].m2 != M_NONE) begin
        drive(vecs[r].m2);
        tick();
        drive(M_NONE);
      end
      finish_move($sformatf("row%0d move", r));
      bus.q_x = 6'(vecs[r].qx);
      bus.q_y = 6'(vecs[r].qy);
      #1;
      check($sformatf("row%0d head_x", r), int'(bus.head_x), vecs[r].ex);
      check($sformatf("row%0d head_y", r), int'(bus.head_y), vecs[r].ey);
      check($sformatf("row%0d len", r), int'(bus.snake_len), vecs[r].elen);
      check($sformatf("row%0d game_over", r), int'(bus.game_over), int'(vecs[r].eover));
      check($sformatf("row%0d q_body", r), int'(bus.q_body), int'(vecs[r].eqb));
    end

    // Straight run to the right wall: x=38 is the last legal cell.
    restart();
    for (int i = 1; i <= 28; i++) begin
      moved = 1'b0;
      finish_move("wall run move");
      check($sformatf("wall run x%0d", i), int'(bus.head_x), 10 + i);
    end
    check("wall run not over", int'(bus.game_over), 0);
    moved = 1'b0;
    finish_move("wall blocked move");
    check("wall game_over", int'(bus.game_over), 1);
    check("wall head_x", int'(bus.head_x), 38);
    check("wall head_y", int'(bus.head_y), 15);
    count_steps(12, steps);
    check("over steps", steps, 0);
    check("over head_x", int'(bus.head_x), 38);

    drive(M_START);
    tick();
    drive(M_NONE);
    check("restart head_x", int'(bus.head_x), 10);
    check("restart len", int'(bus.snake_len), 3);
    check("restart game_over", int'(bus.game_over), 0);
    moved = 1'b0;
    finish_move("restart move");
    check("restart move x", int'(bus.head_x), 11);

    // Stone hit mid-interval freezes the snake on the following edge.
    tick();
    drive(M_STONE);
    tick();
    drive(M_NONE);
    check("stone game_over", int'(bus.game_over), 1);
    check("stone head_x", int'(bus.head_x), 11);
    count_steps(12, steps);
    check("stone steps", steps, 0);
    check("stone hold x", int'(bus.head_x), 11);
    check("stone hold y", int'(bus.head_y), 15);

    // Asynchronous reset mid-run, checked before any further clock edge.
    drive(M_START);
    tick();
    drive(M_NONE);
    moved = 1'b0;
    finish_move("pre-reset move1");
    moved = 1'b0;
    finish_move("pre-reset move2");
    hx = int'(bus.head_x);
    check("pre-reset x", hx, 12);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst head_x", int'(bus.head_x), 10);
    check("async rst head_y", int'(bus.head_y), 15);
    check("async rst len", int'(bus.snake_len), 3);
    check("async rst game_over", int'(bus.game_over), 0);
    bus.q_x = 6'd9;
    bus.q_y = 6'd15;
    #1;
    check("async rst q_body 9,15", int'(bus.q_body), 1);
    bus.q_x = 6'd7;
    #1;
    check("async rst q_body 7,15", int'(bus.q_body), 0);
    bus.q_x = 6'd11;
    #1;
    check("async rst q_body 11,15", int'(bus.q_body), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_steps(8, steps);
    check("post-rst idle steps", steps, 0);
    drive(M_START);
    tick();
    drive(M_NONE);
    moved = 1'b0;
    finish_move("post-rst move");
    check("post-rst dir x", int'(bus.head_x), 11);
    check("post-rst dir y", int'(bus.head_y), 15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
